counter_nbit: RTL

Parametrised successor to the 4-bit LED counter. It is an N-bit up/down counter driven by an internal clock-enable prescaler, with a synchronous parallel load, a wrap or saturate mode, and one-cycle `tick` and terminal-count pulses. It sits directly behind the board clock and drives the LED bank or any downstream logic that needs a slow, observable count.

---
 rtl/counter_nbit_pkg.sv | 14 +
 rtl/counter_nbit_tick_gen.sv | 39 +++
 rtl/counter_nbit.sv | 89 ++++++++
 3 files changed

// File: rtl/counter_nbit_pkg.sv
// Shared types and helpers for the N-bit LED counter and its prescaler.
package counter_nbit_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Prescaler register width: never narrower than one bit, even for DIV_CYCLES of 1 or 2.
  function automatic int unsigned pre_width(input int unsigned div_cycles);
    return (div_cycles <= 2) ? 1 : $clog2(div_cycles);
  endfunction

endpackage

// File: rtl/counter_nbit_tick_gen.sv
// Clock-enable prescaler: raises hit on the enabled cycle that completes a DIV_CYCLES period.
module counter_nbit_tick_gen
  import counter_nbit_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic hit
);

  localparam int unsigned PW = pre_width(DIV_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV_CYCLES - 1);

  logic [PW-1:0] pre_q, pre_d;

  // With DIV_CYCLES=1 every enabled cycle hits, so pre never leaves 0.
  assign hit = en && (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q;
    if (clr || hit) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/counter_nbit.sv
// N-bit up/down LED counter with prescaled steps, synchronous load, wrap/saturate and tick/tc pulses.
module counter_nbit
  import counter_nbit_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DIV_CYCLES = 100_000_000,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic             hit;
  logic [WIDTH-1:0] led_q, led_d, next_val;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;
  logic             at_bound;

  counter_nbit_tick_gen #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .hit  (hit)
  );

  // Next count and bound detection for the current direction.
  always_comb begin
    at_bound = 1'b0;
    next_val = led_q;
    if (dir_e'(dir) == DIR_UP) begin
      at_bound = (led_q == MAX_VAL);
      if (!at_bound) begin
        next_val = led_q + WIDTH'(1);
      end else if (!SATURATE) begin
        next_val = '0;
      end
    end else begin
      at_bound = (led_q == '0);
      if (!at_bound) begin
        next_val = led_q - WIDTH'(1);
      end else if (!SATURATE) begin
        next_val = MAX_VAL;
      end
    end
  end

  // Load wins over a coincident step; the step is simply dropped.
  always_comb begin
    led_d  = led_q;
    tick_d = 1'b0;
    tc_d   = 1'b0;
    if (load) begin
      led_d = load_val;
    end else if (hit) begin
      led_d  = next_val;
      tick_d = 1'b1;
      tc_d   = at_bound;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q  <= '0;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      led_q  <= led_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;
  assign tc   = tc_q;

endmodule
